// File: rtl/mips_divider_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package mips_div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Iteration counter must hold values 0..WIDTH.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mips_divider_if.sv
// Request/result bundle between EX-stage control and the divider.
interface mips_divider_if
    import mips_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mips_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);
    logic [WIDTH-1:0] low;
    logic [WIDTH:0]   trial;

    // The shifted-out MSB of partial_rem is the implicit bit WIDTH of the shifted value;
    // when set, the shifted value already exceeds any divisor and the low bits of the
    // difference are the exact new remainder.
    always_comb begin
        low     = {partial_rem[WIDTH-2:0], next_bit};
        trial   = {1'b0, low} - {1'b0, divisor_mag};
        q_bit   = partial_rem[WIDTH-1] | ~trial[WIDTH];
        new_rem = q_bit ? trial[WIDTH-1:0] : low;
    end
endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU, results to HI (remainder) / LO (quotient).
// Optional early-out for |dividend| < |divisor| enabled by MIPS_DIV_EARLY_OUT_EN.
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    mips_divider_if.slave  bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_mag;
    logic             sign_q;
    logic             sign_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             early;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes and sign capture for signed requests.
    always_comb begin
        dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
        dsr_neg = bus.is_signed & bus.divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        dsr_mag = dsr_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
        q_fix   = sign_q ? (~quo_q + WIDTH'(1)) : quo_q;
        r_fix   = sign_r ? (~rem_q + WIDTH'(1)) : rem_q;
    end

`ifdef MIPS_DIV_EARLY_OUT_EN
    assign early = (dvd_mag < dsr_mag);
`else
    assign early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem (rem_q),
        .next_bit    (quo_q[WIDTH-1]),
        .divisor_mag (div_mag),
        .new_rem     (step_rem),
        .q_bit       (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sign_q  <= dvd_neg ^ dsr_neg;
                        sign_r  <= dvd_neg;
                        div_mag <= dsr_mag;
                        cnt     <= '0;
                        if (bus.divisor == '0) begin
                            // Divide by zero resolves immediately, no iteration.
                            state       <= DONE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end else if (early) begin
                            state  <= FIXUP;
                            busy_r <= 1'b1;
                            quo_q  <= '0;
                            rem_q  <= dvd_mag;
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                            quo_q  <= dvd_mag;
                            rem_q  <= '0;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    // quo_q shifts the dividend out while quotient bits shift in.
                    quo_q <= {quo_q[WIDTH-2:0], step_q};
                    rem_q <= step_rem;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state       <= DONE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    quotient_r  <= q_fix;
                    remainder_r <= r_fix;
                    dbz_r       <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule
